// File: rtl/ds_upsizer.sv
// Data-stream width upsizer: packs RATIO narrow beats into one wide word, flushing early on i_last.
// Optional build macro DS_UPSIZER_MSB_FIRST_EN fills lanes from the top lane down.
`timescale 1ns/1ps
module ds_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_last,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [IN_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]          o_keep,
  output logic                      o_last,
  output logic                      o_valid,
  input  logic                      i_ready
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RATIO - 1);
  localparam logic [RATIO-1:0] KEEP_ONE = RATIO'(1);

  generate
    if (RATIO < 2 || IN_WIDTH < 1) begin : g_bad_params
      $error("ds_upsizer: RATIO must be >= 2 and IN_WIDTH >= 1");
    end
  endgenerate

  // Lane targeted by the beat that arrives while the counter holds cnt.
  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] cnt);
`ifdef DS_UPSIZER_MSB_FIRST_EN
    return CNT_MAX - cnt;
`else
    return cnt;
`endif
  endfunction

  logic [OUT_WIDTH-1:0] pack_q;
  logic [RATIO-1:0]     keep_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [CNT_W-1:0]     lane;
  logic [OUT_WIDTH-1:0] pack_ins;
  logic [RATIO-1:0]     keep_ins;
  logic                 completing;
  logic                 in_xfer;
  logic                 out_xfer;

  assign o_ready  = !o_valid || i_ready;
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  always_comb begin
    lane       = lane_of(cnt_q);
    pack_ins   = pack_q;
    pack_ins[int'(lane)*IN_WIDTH +: IN_WIDTH] = i_data;
    keep_ins   = keep_q | (KEEP_ONE << lane);
    completing = (cnt_q == CNT_MAX) || i_last;
  end

  // A completing beat moves the merged word to the output register in the same edge
  // the previous word may be leaving, so streaming never inserts a bubble.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pack_q  <= '0;
      keep_q  <= '0;
      cnt_q   <= '0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else if (in_xfer) begin
      if (completing) begin
        o_data  <= pack_ins;
        o_keep  <= keep_ins;
        o_last  <= i_last;
        o_valid <= 1'b1;
        pack_q  <= '0;
        keep_q  <= '0;
        cnt_q   <= '0;
      end else begin
        pack_q <= pack_ins;
        keep_q <= keep_ins;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (out_xfer) o_valid <= 1'b0;
      end
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_upsizer.sv
// Directed testbench for ds_upsizer (IN_WIDTH=8, RATIO=4); expectations follow the
// lane order of the build selected by DS_UPSIZER_MSB_FIRST_EN.
`timescale 1ns/1ps
module tb_ds_upsizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_last = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;
  logic        o_valid;
  logic        i_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_low = 0;
  logic [36:0] words[$];

  ds_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output transfer a little before the edge that completes it.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && o_valid && i_ready) words.push_back({o_last, o_keep, o_data});
    if (rst_n && !o_ready) ready_low = ready_low + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    i_data  = d;
    i_last  = l;
    i_valid = 1'b1;
    #1;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!o_ready) check_val("send_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic l);
    int n;
    logic [36:0] w;
    n = 0;
    while (words.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (words.size() == 0) begin
      check_val({tag, "_missing"}, 0, 1);
    end else begin
      w = words.pop_front();
      check_val({tag, "_data"}, w[31:0], d);
      check_val({tag, "_keep"}, w[35:32], k);
      check_val({tag, "_last"}, w[36], l);
    end
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", o_ready, 1);
    rst_net_release: begin
      rst_n = 1'b1;
    end
    @(negedge clk);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_keep", o_keep, 0);
    check_val("rst_last", o_last, 0);
    check_val("rst_ready_after", o_ready, 1);

`ifdef DS_UPSIZER_MSB_FIRST_EN
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check_val("msb_full_valid", o_valid, 1);
    expect_word("msb_full", 32'h11223344, 4'b1111, 0);
    send(8'h99, 1);
    expect_word("msb_single", 32'h99000000, 4'b1000, 1);
    send(8'hA1, 0); send(8'hB2, 1);
    expect_word("msb_partial", 32'hA1B20000, 4'b1100, 1);
`else
    // Full word, output valid for exactly one cycle
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check_val("full_valid", o_valid, 1);
    check_val("full_data_reg", o_data, 32'h44332211);
    @(negedge clk);
    check_val("full_valid_drop", o_valid, 0);
    expect_word("full", 32'h44332211, 4'b1111, 0);

    // Partial flush on i_last, then the next word restarts at lane 0
    send(8'hA1, 0); send(8'hB2, 1);
    expect_word("partial", 32'h0000B2A1, 4'b0011, 1);
    send(8'hC3, 0); send(8'hC4, 0); send(8'hC5, 0); send(8'hC6, 0);
    expect_word("after_partial", 32'hC6C5C4C3, 4'b1111, 0);
    send(8'h7E, 1);
    expect_word("single", 32'h0000007E, 4'b0001, 1);

    // Backpressure: held output and stalled input for 5 cycles
    i_ready = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    i_data = 8'h05; i_last = 1'b0; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check_val("bp_ready", o_ready, 0);
      check_val("bp_hold", o_data, 32'h04030201);
    end
    check_val("bp_keep", o_keep, 4'b1111);
    check_val("bp_last", o_last, 1);
    i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    send(8'h06, 0); send(8'h07, 0); send(8'h08, 0);
    expect_word("bp_first", 32'h04030201, 4'b1111, 1);
    expect_word("bp_second", 32'h08070605, 4'b1111, 0);

    // Back-to-back stream: one beat per cycle, no stall
    repeat (3) @(negedge clk);
    ready_low = 0;
    t0 = cyc;
    for (int b = 0; b < 16; b++) send(8'(b), 0);
    check_val("b2b_cycles", cyc - t0, 16);
    check_val("b2b_no_stall", ready_low, 0);
    expect_word("b2b_0", 32'h03020100, 4'b1111, 0);
    expect_word("b2b_1", 32'h07060504, 4'b1111, 0);
    expect_word("b2b_2", 32'h0B0A0908, 4'b1111, 0);
    expect_word("b2b_3", 32'h0F0E0D0C, 4'b1111, 0);

    // Reset mid-word discards the partial lanes
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("midrst_valid", o_valid, 0);
    check_val("midrst_ready", o_ready, 1);
    send(8'h55, 0); send(8'h56, 0); send(8'h57, 0); send(8'h58, 0);
    expect_word("midrst", 32'h58575655, 4'b1111, 0);
`endif

    repeat (5) @(negedge clk);
    check_val("no_extra_words", words.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ds_upsizer.md
Name: ds_upsizer

Overview:
- Data-stream width upsizer that packs RATIO consecutive IN_WIDTH-bit beats into one IN_WIDTH*RATIO-bit word.
- Sits directly upstream of the data-stream fifo, so narrow producers can fill wide FIFO entries.
- Valid/ready handshake on both sides.
- Packet boundary (i_last) flushes a partially filled word, with a lane-valid mask.

Parameters:
- IN_WIDTH, 8: width of one input beat in bits; must be >= 1.
- RATIO, 4: input beats per output word; must be >= 2, otherwise elaboration error.
- OUT_WIDTH, IN_WIDTH*RATIO: derived localparam, not overridable.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-low (0 = reset).
- i_data  in  IN_WIDTH  input beat.
- i_last  in  1  beat is the last of a packet.
- i_valid  in  1  input beat valid.
- o_ready  out  1  upsizer accepts the input beat.
- o_data  out  OUT_WIDTH  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- o_keep  out  RATIO  lane k holds valid data.
- o_last  out  1  word ends a packet.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream (fifo) accepts the word.

Behaviour:
- Handshakes:
  - Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
  - o_ready = !o_valid | i_ready (combinational from i_ready only, never from i_valid).
- Internal state:
  - Packing register pack_q (OUT_WIDTH), lane mask keep_q (RATIO), lane counter cnt_q (clog2(RATIO) bits, range 0..RATIO-1).
  - Output register holding o_data, o_keep, o_last, o_valid.
- Non-completing input beat (cnt_q < RATIO-1 and i_last = 0):
  - Lane cnt_q of pack_q <= i_data; keep_q[cnt_q] <= 1; cnt_q++.
- Completing input beat (cnt_q = RATIO-1 or i_last = 1):
  - Output register <= pack_q with lane cnt_q replaced by i_data.
  - o_keep <= keep_q | (1 << cnt_q); o_last <= i_last; o_valid <= 1.
  - pack_q <= 0; keep_q <= 0; cnt_q <= 0.
- Output hold and drain:
  - If o_valid & !i_ready: o_data, o_keep, o_last are held stable and no input is accepted.
  - Output transfer without a completing input in the same cycle: o_valid <= 0.
- Unfilled lanes of a partial word read 0; o_keep marks only the filled lanes.
- Latency: completing beat accepted in cycle N -> o_valid = 1 in cycle N+1.
- Throughput: one input beat per cycle sustained while i_ready = 1; one output word per RATIO beats.
- Simultaneous completing input and output transfer: the old word leaves and the new word loads in the same edge; o_valid stays 1, no bubble.
- i_last on the first beat (cnt_q = 0) gives a one-lane word: o_keep = 1 (only bit 0 set).
- i_last at cnt_q = RATIO-1 gives a full word with o_last = 1.
- Counter wrap: cnt_q wraps RATIO-1 -> 0 only on a completing beat; no other wrap path.
- Reset (i_rst = 0), including mid-word or mid-packet:
  - Next edge: o_valid = 0, o_data = 0, o_keep = 0, o_last = 0, pack_q = 0, keep_q = 0, cnt_q = 0.
  - Any partially packed lanes are discarded.
  - o_ready = 1 during and after reset (o_valid = 0).
- Protocol obligations:
  - Upstream holds i_data and i_last stable while i_valid & !o_ready.
  - o_valid is never withdrawn before the output transfer completes.

Optional Feature:
- Macro DS_UPSIZER_MSB_FIRST_EN.
- Defined: lane fill order is reversed. The first beat of a word goes to lane RATIO-1 and the k-th beat to lane RATIO-1-k. o_keep bits are set in the same reversed order, so a one-beat partial word gives o_keep = 1 << (RATIO-1).
- Undefined (default): LSB-first; the first beat goes to lane 0.
- Counter, handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Full-word packing, default build, IN_WIDTH=8, RATIO=4, i_ready=1: beats 0x11, 0x22, 0x33, 0x44, no last -> one cycle after the 4th accept, o_data=0x44332211, o_keep=4'b1111, o_last=0, o_valid=1 for exactly one cycle.
- Partial flush: beats 0xA1, 0xB2 with i_last on the 2nd -> o_data=0x0000B2A1, o_keep=4'b0011, o_last=1; the next word starts at lane 0.
- Backpressure: i_ready=0 while a word is valid, upstream streaming -> o_ready=0; o_data held stable for 5 cycles; no beat lost or duplicated after i_ready returns to 1.
- Back-to-back streaming: 16 consecutive beats 0x00..0x0F, i_ready=1 -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; o_ready=1 every cycle, no bubbles.
- Reset mid-word: 3 beats accepted, then i_rst=0 for 1 cycle, then beats 0x55..0x58 -> the first 3 beats never appear; output 0x58575655 with o_keep=4'b1111.
- MSB-first build (DS_UPSIZER_MSB_FIRST_EN): beats 0x11, 0x22, 0x33, 0x44 -> o_data=0x11223344; a single 0x99 with i_last -> o_data=0x99000000, o_keep=4'b1000.
